// File: rtl/mem_responder_if.sv
// rtl/mem_responder_if.sv - link lanes, SRAM port and status signals of the memory responder
// Signals:
//   rx_pins   - command frames from the CPU (start, header, payload lanes)
//   tx_pins   - response frames to the CPU
//   mem_addr  - SRAM word address
//   mem_wdata - SRAM write data
//   mem_we    - one-cycle SRAM write strobe
//   mem_re    - one-cycle SRAM read strobe, mem_rdata valid the following cycle
//   mem_rdata - SRAM read data
//   busy      - receive, execute, capture or transmit activity in progress
//   error     - sticky response-FIFO overflow
//   tx_stall  - test hook: holds the response FIFO undrained while high (tie low in use)
interface mem_responder_if #(
    parameter int IO_BITS        = 2,
    parameter int PAYLOAD_CYCLES = 8,
    parameter int ADDR_BITS      = 8
);
    localparam int PW = IO_BITS * PAYLOAD_CYCLES;

    logic [IO_BITS-1:0]   rx_pins;
    logic [IO_BITS-1:0]   tx_pins;
    logic [ADDR_BITS-1:0] mem_addr;
    logic [PW-1:0]        mem_wdata;
    logic                 mem_we;
    logic                 mem_re;
    logic [PW-1:0]        mem_rdata;
    logic                 busy;
    logic                 error;
    logic                 tx_stall;

    modport slave (
        input  rx_pins, mem_rdata, tx_stall,
        output tx_pins, mem_addr, mem_wdata, mem_we, mem_re, busy, error
    );

    modport master (
        output rx_pins, mem_rdata, tx_stall,
        input  tx_pins, mem_addr, mem_wdata, mem_we, mem_re, busy, error
    );
endinterface

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - start-bit serial memory responder: decodes command frames, drives SRAM, returns read data
// Ports:
//   clk   - clock
//   reset - asynchronous active-high reset, clears all state and discards partial frames
//   bus   - mem_responder_if.slave: rx/tx lanes, SRAM port, busy/error status, tx_stall hook
module mem_responder #(
    parameter int                 IO_BITS        = 2,
    parameter int                 TX_CMD_BITS    = 2,
    parameter int                 PAYLOAD_CYCLES = 8,
    parameter int                 ADDR_BITS      = 8,
    parameter logic [IO_BITS-1:0] RESP_SB        = IO_BITS'(1)
) (
    input  logic           clk,
    input  logic           reset,
    mem_responder_if.slave bus
);
    localparam int PW    = IO_BITS * PAYLOAD_CYCLES;
    localparam int CNT_W = (PAYLOAD_CYCLES > 1) ? $clog2(PAYLOAD_CYCLES) : 1;
    localparam logic [CNT_W-1:0]       CNT_LAST  = CNT_W'(PAYLOAD_CYCLES - 1);
    localparam logic [TX_CMD_BITS-1:0] CMD_ADDR  = TX_CMD_BITS'(0);
    localparam logic [TX_CMD_BITS-1:0] CMD_WRITE = TX_CMD_BITS'(1);
    localparam logic [TX_CMD_BITS-1:0] CMD_READ  = TX_CMD_BITS'(2);

    typedef enum logic [1:0] {RX_IDLE, RX_HDR, RX_PAY} rx_state_t;
    typedef enum logic [1:0] {TX_IDLE, TX_DATA, TX_GAP} tx_state_t;

    // receive side
    rx_state_t              rx_state_q, rx_state_d;
    logic [CNT_W-1:0]       rx_cnt_q, rx_cnt_d;
    logic [TX_CMD_BITS-1:0] cmd_q, cmd_d;
    logic [PW-1:0]          pay_q, pay_d;
    logic                   rx_last;

    // execution side
    logic [ADDR_BITS-1:0]   addr_reg_q, addr_reg_d;
    logic [ADDR_BITS-1:0]   mem_addr_q, mem_addr_d;
    logic [PW-1:0]          mem_wdata_q, mem_wdata_d;
    logic                   mem_we_q, mem_we_d;
    logic                   mem_re_q, mem_re_d;
    logic                   exec_q;
    logic                   cap_q;

    // response FIFO (two entries)
    logic [PW-1:0]          fifo_q [2];
    logic                   wr_ptr_q, rd_ptr_q;
    logic [1:0]             count_q;
    logic                   fifo_empty, fifo_full;
    logic                   push, pop, push_ok, overflow;
    logic                   error_q;

    // transmit side
    tx_state_t              tx_state_q, tx_state_d;
    logic [CNT_W-1:0]       tx_cnt_q, tx_cnt_d;
    logic [PW-1:0]          tx_sh_q, tx_sh_d;
    logic [IO_BITS-1:0]     tx_lane;

    // Receive FSM. Payload is shifted in from the top so that after the last
    // beat the first (least significant) beat sits at bit 0.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        cmd_d      = cmd_q;
        pay_d      = pay_q;
        rx_last    = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (bus.rx_pins[0]) begin
                    rx_state_d = RX_HDR;
                end
            end
            RX_HDR: begin
                cmd_d      = bus.rx_pins[TX_CMD_BITS-1:0];
                rx_cnt_d   = '0;
                rx_state_d = RX_PAY;
            end
            RX_PAY: begin
                pay_d    = {bus.rx_pins, pay_q[PW-1:IO_BITS]};
                rx_cnt_d = rx_cnt_q + CNT_W'(1);
                if (rx_cnt_q == CNT_LAST) begin
                    rx_state_d = RX_IDLE;
                    rx_last    = 1'b1;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // Command execution is decided on the last payload beat and registered, so
    // the strobes and address are visible for exactly the following cycle.
    always_comb begin
        addr_reg_d  = addr_reg_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = 1'b0;
        mem_re_d    = 1'b0;
        if (rx_last) begin
            case (cmd_q)
                CMD_ADDR: begin
                    addr_reg_d = pay_d[ADDR_BITS-1:0];
                end
                CMD_WRITE: begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = addr_reg_q;
                    mem_wdata_d = pay_d;
                    addr_reg_d  = addr_reg_q + ADDR_BITS'(1);
                end
                CMD_READ: begin
                    mem_re_d   = 1'b1;
                    mem_addr_d = pay_d[ADDR_BITS-1:0];
                end
                default: ;
            endcase
        end
    end

    assign fifo_empty = (count_q == 2'd0);
    assign fifo_full  = (count_q == 2'd2);
    assign push       = cap_q;
    // A pop in the same cycle frees the slot, so push-while-full is only an
    // overflow when nothing is leaving.
    assign push_ok    = push && (!fifo_full || pop);
    assign overflow   = push && fifo_full && !pop;

    // Transmit FSM. TX_GAP guarantees at least one zero cycle between frames.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_sh_d    = tx_sh_q;
        tx_lane    = '0;
        pop        = 1'b0;
        case (tx_state_q)
            TX_IDLE: begin
                if (!fifo_empty && !bus.tx_stall) begin
                    tx_lane    = RESP_SB;
                    pop        = 1'b1;
                    tx_sh_d    = fifo_q[rd_ptr_q];
                    tx_cnt_d   = '0;
                    tx_state_d = TX_DATA;
                end
            end
            TX_DATA: begin
                tx_lane  = tx_sh_q[IO_BITS-1:0];
                tx_sh_d  = tx_sh_q >> IO_BITS;
                tx_cnt_d = tx_cnt_q + CNT_W'(1);
                if (tx_cnt_q == CNT_LAST) begin
                    tx_state_d = TX_GAP;
                end
            end
            TX_GAP:  tx_state_d = TX_IDLE;
            default: tx_state_d = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_state_q  <= RX_IDLE;
            rx_cnt_q    <= '0;
            cmd_q       <= '0;
            pay_q       <= '0;
            addr_reg_q  <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            mem_re_q    <= 1'b0;
            exec_q      <= 1'b0;
            cap_q       <= 1'b0;
            fifo_q[0]   <= '0;
            fifo_q[1]   <= '0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            count_q     <= 2'd0;
            error_q     <= 1'b0;
            tx_state_q  <= TX_IDLE;
            tx_cnt_q    <= '0;
            tx_sh_q     <= '0;
        end else begin
            rx_state_q  <= rx_state_d;
            rx_cnt_q    <= rx_cnt_d;
            cmd_q       <= cmd_d;
            pay_q       <= pay_d;
            addr_reg_q  <= addr_reg_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
            mem_re_q    <= mem_re_d;
            exec_q      <= rx_last;
            // SRAM returns data the cycle after the read strobe.
            cap_q       <= mem_re_q;
            if (push_ok) begin
                fifo_q[wr_ptr_q] <= bus.mem_rdata;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({push_ok, pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: ;
            endcase
            if (overflow) begin
                error_q <= 1'b1;
            end
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_sh_q    <= tx_sh_d;
        end
    end

    assign bus.tx_pins   = tx_lane;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_re    = mem_re_q;
    assign bus.error     = error_q;
    assign bus.busy      = (rx_state_q != RX_IDLE) || exec_q || cap_q ||
                           !fifo_empty || (tx_state_q != TX_IDLE);
endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side end of the start-bit serial link driven by the CPU's memory interface.
- Decodes command frames arriving on `rx_pins` and executes them against a synchronous SRAM port.
- Returns read data as response frames on `tx_pins`.
- Serves as the synthesizable RAM model for FPGA/sim builds and as the protocol reference for the external memory controller.

Parameters:
- IO_BITS, 2, width of each pin lane.
- TX_CMD_BITS, 2, command header width carried in one cycle; must be <= IO_BITS.
- PAYLOAD_CYCLES, 8, payload cycles per frame; payload width PW = IO_BITS*PAYLOAD_CYCLES (16).
- ADDR_BITS, 8, SRAM word address width.
- RESP_SB, 1, start-bit value of a response frame; nonzero, IO_BITS wide.

Ports:
- clk, input, 1, clock.
- reset, input, 1, asynchronous active-high reset.
- rx_pins, input, IO_BITS, command frames from CPU.
- tx_pins, output, IO_BITS, response frames to CPU.
- mem_addr, output, ADDR_BITS, SRAM word address.
- mem_wdata, output, PW, SRAM write data.
- mem_we, output, 1, one-cycle write strobe.
- mem_re, output, 1, one-cycle read strobe; mem_rdata valid the following cycle.
- mem_rdata, input, PW, SRAM read data.
- busy, output, 1, high while a frame is being received or a response is pending or being sent.
- error, output, 1, sticky response-FIFO overflow flag.

Behaviour:
Reset:
- Asynchronous; all state cleared immediately.
- tx_pins=0, mem_we=0, mem_re=0, mem_addr=0, mem_wdata=0, busy=0, error=0, addr_reg=0, FIFO empty.
- Any partial frame in either direction is discarded.

Command frame (rx):
- Idle lanes are all 0.
- Start cycle: rx_pins[0]=1; upper bits ignored. In IDLE with rx_pins[0]=0, rx_pins is ignored.
- Header cycle: cmd = rx_pins[TX_CMD_BITS-1:0].
- PAYLOAD_CYCLES payload cycles follow, LSB first: cycle k carries payload[IO_BITS*k +: IO_BITS].

Receive FSM:
- IDLE -> HDR on start; HDR -> PAY (cnt=0); PAY increments cnt; at cnt=PAYLOAD_CYCLES-1 -> IDLE and raises exec for the next cycle.
- A new start bit is accepted in the very cycle after the last payload cycle, i.e. concurrent with exec.

Execution (exec cycle E, one cycle after the last payload cycle T):
- cmd 0 ADDR: addr_reg <= payload[ADDR_BITS-1:0]. No strobe.
- cmd 1 WRITE: mem_we=1, mem_addr=addr_reg, mem_wdata=payload. addr_reg <= addr_reg+1, wrapping mod 2^ADDR_BITS.
- cmd 2 READ: mem_re=1, mem_addr=payload[ADDR_BITS-1:0]. addr_reg unchanged. mem_rdata is captured at E+1 and pushed into the response FIFO.
- cmd 3: no side effects, no response.
- Address payload bits above ADDR_BITS are ignored.

Response FIFO:
- Depth 2.
- A push when full drops the data and sets error; error clears only on reset.
- Simultaneous push and pop when full is not an overflow.

Transmit FSM:
- TIDLE: when the FIFO is non-empty and the gap is satisfied, drive tx_pins=RESP_SB for one cycle and pop an entry.
- Then PAYLOAD_CYCLES cycles of data, LSB first, same lane order as rx.
- Then tx_pins=0 for at least one cycle before the next start.
- tx_pins=0 whenever not in a start or payload cycle.

Latency:
- For a READ whose last payload cycle is T: mem_re at T+1, FIFO write at T+2, response start bits at T+3, data at T+4..T+3+PAYLOAD_CYCLES.
- When tx is idle this latency is exact.

Concurrency:
- Receive and transmit are independent; commands may arrive while a response is being sent.
- busy = receive FSM not IDLE, or exec pending, or read capture pending, or FIFO non-empty, or transmit FSM active.

Test Plan:
1. ADDR 0x0010, then WRITE 0xBEEF, then WRITE 0x1234.
   -> mem_we pulses at E with mem_addr=0x10, mem_wdata=0xBEEF.
   -> then mem_addr=0x11, mem_wdata=0x1234.
   -> tx_pins stays 0 throughout.
2. READ 0x0011, SRAM model returns 0x1234.
   -> mem_re at T+1 with mem_addr=0x11.
   -> tx_pins=01 at T+3, then 0,1,3,0,2,0,1,0 on T+4..T+11.
   -> tx_pins=0 at T+12.
3. Two READs back-to-back (second start at T+1), data 0xAAAA then 0x5555.
   -> two complete response frames in order, at least one zero cycle between them, error=0.
4. cmd 3 frame with payload 0xFFFF.
   -> no mem_we/mem_re, no response, addr_reg unchanged; busy returns to 0 at T+2.
5. Reset asserted during payload cycle 4 of a WRITE.
   -> all outputs 0 immediately, no mem_we.
   -> after release, a full ADDR 0x0003 + WRITE 0x0101 frame pair executes with mem_addr=0x03.
6. ADDR 0xFFFF (ADDR_BITS=8), then two WRITEs.
   -> mem_addr=0xFF, then 0x00 (wrap).
   -> separately, force 3 READ responses while holding the tx FIFO undrained via a stalled-tx test hook, and check error=1 stays set until reset.
